// File: rtl/countdown_scan_2digit.sv
// countdown_scan_2digit: 2-digit BCD countdown with run/hold FSM and multiplexed digit-scan outputs
module countdown_scan_2digit #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       run,
  input  logic       disp_en,
  output logic [3:0] bin,
  output logic       blank,
  output logic [1:0] an,
  output logic       busy,
  output logic       done
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, nstate;
  logic [3:0] tens, ones, n_tens, n_ones;
  logic [PW-1:0] pre, n_pre;
  logic [SW-1:0] scnt;
  logic [6:0] sat;
  logic sel, n_done, tick, swrap;
  always_comb begin
    sat = load_val > 7'd99 ? 7'd99 : load_val;
    tick = state == RUN && run && pre == PW'(TICK_DIV - 1);
    nstate = state;
    n_tens = tens;
    n_ones = ones;
    n_pre = pre;
    n_done = 1'b0;
    if (load) begin
      n_tens = 4'(sat / 7'd10);
      n_ones = 4'(sat % 7'd10);
      n_pre = '0;
      nstate = sat == 7'd0 ? IDLE : run ? RUN : HOLD;
    end else if (state != IDLE) begin
      nstate = run ? RUN : HOLD;
      if (state == RUN && run) n_pre = tick ? '0 : pre + 1'b1;
      if (tick) begin
        n_ones = ones != 4'd0 ? ones - 1'b1 : 4'd9;
        n_tens = ones != 4'd0 ? tens : tens - 1'b1;
        if (tens == 4'd0 && ones == 4'd1) begin
          nstate = IDLE;
          n_done = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tens <= 4'd0;
      ones <= 4'd0;
      pre <= '0;
      done <= 1'b0;
    end else begin
      state <= nstate;
      tens <= n_tens;
      ones <= n_ones;
      pre <= n_pre;
      done <= n_done;
    end
  end
  assign busy = state != IDLE;
  assign swrap = scnt == SW'(SCAN_DIV - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
      sel <= 1'b0;
      an <= 2'b11;
      bin <= 4'd0;
      blank <= 1'b1;
    end else begin
      scnt <= swrap ? '0 : scnt + 1'b1;
      sel <= swrap ? ~sel : sel;
      an <= sel ? 2'b01 : 2'b10;
      bin <= sel ? tens : ones;
      blank <= !disp_en || (sel && tens == 4'd0);
    end
  end
endmodule

// File: tb/tb_countdown_scan_2digit.sv
// tb_countdown_scan_2digit: scoreboard bench for countdown_scan_2digit
module tb_countdown_scan_2digit;
  localparam int K_CNT = 0, K_BUSY = 1, K_DONE = 2, K_AN = 3, K_BIN = 4, K_BLANK = 5, K_PRE = 6;
  logic clk, rst, load, run, disp_en;
  logic [6:0] load_val;
  logic [3:0] bin;
  logic blank, busy, done;
  logic [1:0] an;
  typedef struct {int cyc; string nm; int k; int v;} exp_t;
  exp_t q[$];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int done_pulses = 0;
  countdown_scan_2digit #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .run(run), .disp_en(disp_en),
    .bin(bin), .blank(blank), .an(an), .busy(busy), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void push(int c, string nm, int k, int v);
    exp_t e;
    e.cyc = c;
    e.nm = nm;
    e.k = k;
    e.v = v;
    q.push_back(e);
  endfunction
  function automatic void push_scan(int c, string nm, int t, int o, bit en);
    int ph = ((c - 4) / 2) % 2;
    push(c, {nm, "_an"}, K_AN, ph != 0 ? 1 : 2);
    push(c, {nm, "_bin"}, K_BIN, ph != 0 ? t : o);
    push(c, {nm, "_blank"}, K_BLANK, (!en || (ph != 0 && t == 0)) ? 1 : 0);
  endfunction
  function automatic int obs(int k);
    case (k)
      K_CNT: return int'(dut.tens) * 10 + int'(dut.ones);
      K_BUSY: return int'(busy);
      K_DONE: return int'(done);
      K_AN: return int'(an);
      K_BIN: return int'(bin);
      K_BLANK: return int'(blank);
      default: return int'(dut.pre);
    endcase
  endfunction
  function automatic void cmp(string nm, int a, int e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endfunction
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (done === 1'b1) done_pulses++;
    cmp("an_both_low", int'(an === 2'b00), 0);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].cyc <= cyc) begin
        if (q[i].cyc < cyc) begin
          compared++;
          mismatched++;
          $display("FAIL %s: missed its cycle %0d (now %0d)", q[i].nm, q[i].cyc, cyc);
        end else cmp(q[i].nm, obs(q[i].k), q[i].v);
        q.delete(i);
      end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic start_load(int v, output int l);
    @(negedge clk);
    load = 1'b1;
    load_val = 7'(v);
    l = cyc + 1;
  endtask
  task automatic end_load();
    @(negedge clk);
    load = 1'b0;
  endtask
  initial begin
    int l, l2;
    rst = 1'b1;
    load = 1'b0;
    load_val = 7'd0;
    run = 1'b0;
    disp_en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      push(c, "rst_cnt", K_CNT, 0);
      push(c, "rst_busy", K_BUSY, 0);
      push(c, "rst_done", K_DONE, 0);
      push(c, "rst_an", K_AN, 3);
      push(c, "rst_blank", K_BLANK, 1);
      push(c, "rst_bin", K_BIN, 0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    start_load(12, l);
    push(l, "A_cnt12", K_CNT, 12);
    push(l, "A_pre0", K_PRE, 0);
    push(l, "A_busy", K_BUSY, 1);
    push(l + 3, "A_cnt12_hold", K_CNT, 12);
    push(l + 4, "A_cnt11", K_CNT, 11);
    push(l + 8, "A_cnt10", K_CNT, 10);
    push(l + 11, "A_cnt10_hold", K_CNT, 10);
    push(l + 12, "A_cnt09", K_CNT, 9);
    end_load();
    wait_cyc(l + 13);
    start_load(2, l);
    push(l, "B_cnt2", K_CNT, 2);
    push(l + 7, "B_done_early", K_DONE, 0);
    push(l + 7, "B_busy_before", K_BUSY, 1);
    push(l + 8, "B_done", K_DONE, 1);
    push(l + 8, "B_cnt0", K_CNT, 0);
    push(l + 8, "B_busy_after", K_BUSY, 0);
    push(l + 9, "B_done_once", K_DONE, 0);
    push(l + 9, "B_idle", K_BUSY, 0);
    end_load();
    wait_cyc(l + 10);
    start_load(120, l);
    push(l, "C_sat99", K_CNT, 99);
    push(l, "C_busy99", K_BUSY, 1);
    end_load();
    start_load(0, l2);
    push(l2, "C_cnt0", K_CNT, 0);
    push(l2, "C_busy0", K_BUSY, 0);
    push(l2, "C_nodone", K_DONE, 0);
    push(l2 + 1, "C_nodone2", K_DONE, 0);
    push_scan(l2 + 2, "C_scan", 0, 0, 1'b1);
    push_scan(l2 + 3, "C_scan", 0, 0, 1'b1);
    end_load();
    wait_cyc(l2 + 4);
    start_load(12, l);
    push(l + 4, "D_cnt11", K_CNT, 11);
    push(l + 6, "D_hold_pre", K_PRE, 1);
    push(l + 15, "D_hold_cnt", K_CNT, 11);
    push(l + 15, "D_hold_busy", K_BUSY, 1);
    push(l + 25, "D_hold_cnt_end", K_CNT, 11);
    push(l + 25, "D_hold_pre_end", K_PRE, 1);
    push(l + 26, "D_resume_pre", K_PRE, 1);
    push(l + 27, "D_resume_pre2", K_PRE, 2);
    push(l + 28, "D_resume_cnt", K_CNT, 11);
    push(l + 29, "D_resume_cnt10", K_CNT, 10);
    push(l + 29, "D_resume_pre0", K_PRE, 0);
    end_load();
    wait_cyc(l + 5);
    run = 1'b0;
    wait_cyc(l + 25);
    run = 1'b1;
    wait_cyc(l + 30);
    run = 1'b0;
    start_load(7, l);
    push(l, "E_cnt7", K_CNT, 7);
    push(l, "E_busy", K_BUSY, 1);
    for (int c = 2; c <= 5; c++) push_scan(l + c, "E_scan", 0, 7, 1'b1);
    push_scan(l + 7, "E_dis", 0, 7, 1'b0);
    push_scan(l + 8, "E_dis", 0, 7, 1'b0);
    end_load();
    wait_cyc(l + 6);
    disp_en = 1'b0;
    wait_cyc(l + 9);
    disp_en = 1'b1;
    run = 1'b1;
    start_load(35, l);
    push(l, "F_cnt35", K_CNT, 35);
    push(l, "F_busy", K_BUSY, 1);
    end_load();
    wait_cyc(l + 1);
    #2 rst = 1'b1;
    #1;
    cmp("F_async_cnt", obs(K_CNT), 0);
    cmp("F_async_pre", obs(K_PRE), 0);
    cmp("F_async_busy", int'(busy), 0);
    cmp("F_async_done", int'(done), 0);
    cmp("F_async_an", int'(an), 3);
    cmp("F_async_blank", int'(blank), 1);
    cmp("F_async_bin", int'(bin), 0);
    push(l + 2, "F_rst_cnt", K_CNT, 0);
    push(l + 2, "F_rst_an", K_AN, 3);
    push(l + 3, "F_rst_busy", K_BUSY, 0);
    wait_cyc(l + 3);
    rst = 1'b0;
    wait_cyc(l + 8);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      compared += q.size();
      mismatched += q.size();
      $display("FAIL drain: %0d expectations never checked", q.size());
    end
    cmp("done_pulse_total", done_pulses, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/countdown_scan_2digit.md
COUNTDOWN_SCAN_2DIGIT -- requirements
Module: countdown_scan_2digit

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clk cycles per count decrement (>=2).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit-scan slot (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  one-cycle request to load a new count.
REQ-006 SHALL have port load_val  input  7  unsigned load value; values above 99 saturate to 99.
REQ-007 SHALL have port run  input  1  1 = count down, 0 = hold.
REQ-008 SHALL have port disp_en  input  1  0 = force both digits blank.
REQ-009 SHALL have port bin  output  4  BCD digit for the downstream 1-digit decoder.
REQ-010 SHALL have port blank  output  1  1 = downstream decoder blanks its segments.
REQ-011 SHALL have port an  output  2  digit enables, active-low; an[0] = ones, an[1] = tens.
REQ-012 SHALL have port busy  output  1  1 while count is non-zero.
REQ-013 SHALL have port done  output  1  one-cycle pulse when count reaches 00.

Function
REQ-014 SHALL hold the count as two BCD registers (tens, ones), each 0..9 at all times.
REQ-015 SHALL use FSM states IDLE (count 00), RUN (count non-zero, run=1) and HOLD (count non-zero, run=0).
REQ-016 SHALL, on load, set tens/ones from the saturated load_val and clear the prescaler on the next edge; the target state is IDLE if the value is 0, otherwise RUN or HOLD per run.
REQ-017 SHALL give load priority over a coincident tick, and SHALL NOT pulse done on a load of 0.
REQ-018 SHALL advance the prescaler 0..TICK_DIV-1 only in RUN, with a tick on the wrap; in HOLD and IDLE the prescaler freezes at its value.
REQ-019 SHALL, on tick, decrement BCD: if ones>0 then ones-1; else ones=9 and tens-1.
REQ-020 SHALL, when the tick takes the count from 01 to 00, enter IDLE and assert done for exactly that next cycle.
REQ-021 SHALL move RUN<->HOLD on the first edge at which run changes, preserving the count and prescaler.
REQ-022 SHALL keep busy=1 exactly when the state is RUN or HOLD.
REQ-023 SHALL run the scan counter 0..SCAN_DIV-1 continuously, independent of state, toggling select sel on each wrap.
REQ-024 SHALL register the outputs: with sel=0, an=2'b10 and bin=ones; with sel=1, an=2'b01 and bin=tens; the outputs lag sel by one cycle.
REQ-025 SHALL assert blank when disp_en=0, or when sel=1 and tens=0 (leading-zero suppression); the ones digit always shows, including 0 in IDLE.
REQ-026 SHALL never assert both an bits low in the same cycle.

Reset
REQ-027 SHALL, while rst=1, force tens=0, ones=0, state IDLE, prescaler 0, scan counter 0, sel=0, bin=0, blank=1, an=2'b11, busy=0, done=0.
REQ-028 SHALL apply reset asynchronously; reset mid-count discards the count and no done pulse is issued.
REQ-029 SHALL resume scanning from sel=0 on the first edge after rst deasserts, with the first registered an=2'b10 on the next edge.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-030 Bench SHALL cover: load_val=12, run=1 -> count 12,11,10,09 at 4-cycle intervals; in the 10->09 step ones wraps to 9 and tens goes 1->0.
REQ-031 Bench SHALL cover: load_val=2, run=1 -> done high exactly 1 cycle, 8 cycles after load; then busy=0 and state IDLE.
REQ-032 Bench SHALL cover: load_val=120 -> count 99; load_val=0 -> busy=0 and no done pulse.
REQ-033 Bench SHALL cover: run=0 mid-count for 20 cycles -> count and prescaler unchanged; run=1 -> decrement resumes at the remaining prescaler distance.
REQ-034 Bench SHALL cover: count 07 scanning -> an alternates 10/01 every 2 cycles, bin 7 then 0 with blank=1 on tens; disp_en=0 -> blank=1 on both digits.
REQ-035 Bench SHALL cover: rst pulse during RUN at count 35 -> all outputs take their REQ-027 values immediately (asynchronously) and done is never asserted.
